// File: rtl/debounce.sv
// Debouncer: accepts a new input level only after STABLE consecutive disagreeing samples.
// Optional 2-FF input synchronizer enabled by defining DEBOUNCE_SYNC_EN.
module debounce #(
  parameter int unsigned STABLE = 1000,
  parameter int unsigned CNT_W  = 16,
  parameter bit          INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic signal,
  output logic level,
  output logic busy,
  output logic glitch
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

  logic             s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             level_d;
  logic             glitch_d;

`ifdef DEBOUNCE_SYNC_EN
  logic s1;
  logic s2;

  // Two-flop synchronizer for asynchronous sources
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= signal;
      s2 <= s1;
    end
  end

  assign s = s2;
`else
  assign s = signal;
`endif

  // Next-state: abort on agreement mid-count, accept after a full disagreeing run
  always_comb begin
    level_d  = level;
    cnt_d    = '0;
    glitch_d = 1'b0;
    if (s == level) begin
      if (cnt != '0) begin
        glitch_d = 1'b1;
      end
    end else if (cnt == CNT_LAST) begin
      level_d = s;
    end else begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  // busy tracks the next counter value so it stays a pure register output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= INIT;
      cnt    <= '0;
      busy   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      level  <= level_d;
      cnt    <= cnt_d;
      busy   <= (cnt_d != '0);
      glitch <= glitch_d;
    end
  end

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce; latency offset adapts to the DEBOUNCE_SYNC_EN build.
`timescale 1ns/1ps
module tb_debounce;

`ifdef DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic clk;
  logic rst;
  logic signal;
  logic level, busy, glitch;
  logic sig1;
  logic level1, busy1, glitch1;

  int total = 0;
  int bad   = 0;

  debounce #(.STABLE(4), .CNT_W(16), .INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .signal(signal),
    .level(level), .busy(busy), .glitch(glitch)
  );

  debounce #(.STABLE(1), .CNT_W(4), .INIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .signal(sig1),
    .level(level1), .busy(busy1), .glitch(glitch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; signal = 1'b1; sig1 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({level, busy, glitch, level1} !== 4'b0000) begin
        bad++;
        $display("FAIL reset k=%0d got level/busy/glitch/level1=%b%b%b%b want 0000",
                 k, level, busy, glitch, level1);
      end
    end
    signal = 1'b0; sig1 = 1'b0;
    rst = 1'b1;
    idle(L + 6);
  endtask

  task automatic test_short_pulse();
    for (int k = 0; k <= L + 4; k++) begin
      signal = (k < 2);
      tick();
      total++;
      if (level !== 1'b0 || busy !== (k == L || k == L + 1) || glitch !== (k == L + 2)) begin
        bad++;
        $display("FAIL short_pulse k=%0d got l/b/g=%b%b%b want %b%b%b", k, level, busy, glitch,
                 1'b0, (k == L || k == L + 1), (k == L + 2));
      end
    end
    idle(L + 4);
  endtask

  task automatic test_clean_step();
    signal = 1'b1;
    for (int k = 0; k <= L + 5; k++) begin
      tick();
      total++;
      if (level !== (k >= L + 3) || busy !== (k >= L && k < L + 3) || glitch !== 1'b0) begin
        bad++;
        $display("FAIL clean_step k=%0d got l/b/g=%b%b%b want %b%b0", k, level, busy, glitch,
                 (k >= L + 3), (k >= L && k < L + 3));
      end
    end
    idle(L + 4);
  endtask

  task automatic test_falling_chatter();
    int  j;
    logic el, eb, eg;
    for (int k = 0; k <= L + 7; k++) begin
      signal = (k == 1);
      tick();
      j = k - L;
      if (k < L) begin
        el = 1'b1; eb = 1'b0; eg = 1'b0;
      end else begin
        el = (j < 5);
        eb = (j == 0 || j == 2 || j == 3 || j == 4);
        eg = (j == 1);
      end
      total++;
      if (level !== el || busy !== eb || glitch !== eg) begin
        bad++;
        $display("FAIL falling_chatter k=%0d got l/b/g=%b%b%b want %b%b%b", k, level, busy,
                 glitch, el, eb, eg);
      end
    end
    idle(L + 4);
  endtask

  task automatic test_toggle();
    int gcount = 0;
    for (int k = 0; k <= L + 9; k++) begin
      signal = (k < 8) && (k % 2 == 0);
      tick();
      if (glitch === 1'b1) gcount++;
      total++;
      if (level !== 1'b0) begin
        bad++;
        $display("FAIL toggle_level k=%0d got %b want 0", k, level);
      end
    end
    total++;
    if (gcount !== 4) begin
      bad++;
      $display("FAIL toggle_glitch_count got %0d want 4", gcount);
    end
    idle(L + 4);
  endtask

  task automatic test_reset_mid_count();
    signal = 1'b1;
    for (int k = 0; k <= 3; k++) tick();
    rst = 1'b0;
    #1;
    total++;
    if (level !== 1'b0 || busy !== 1'b0 || glitch !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async got l/b/g=%b%b%b want 000", level, busy, glitch);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (level !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_hold k=%0d got l/b=%b%b want 00", k, level, busy);
      end
    end
    rst = 1'b1;
    for (int k = 0; k <= L + 4; k++) begin
      tick();
      total++;
      if (level !== (k >= L + 3) || busy !== (k >= L && k < L + 3)) begin
        bad++;
        $display("FAIL reset_mid_recount k=%0d got l/b=%b%b want %b%b", k, level, busy,
                 (k >= L + 3), (k >= L && k < L + 3));
      end
    end
  endtask

  task automatic test_stable_one();
    idle(L + 4);
    sig1 = 1'b1;
    for (int k = 0; k <= L + 2; k++) begin
      tick();
      total++;
      if (level1 !== (k >= L) || busy1 !== 1'b0 || glitch1 !== 1'b0) begin
        bad++;
        $display("FAIL stable_one_rise k=%0d got l/b/g=%b%b%b want %b00", k, level1, busy1,
                 glitch1, (k >= L));
      end
    end
    sig1 = 1'b0;
    for (int k = 0; k <= L + 2; k++) begin
      tick();
      total++;
      if (level1 !== (k < L) || busy1 !== 1'b0 || glitch1 !== 1'b0) begin
        bad++;
        $display("FAIL stable_one_fall k=%0d got l/b/g=%b%b%b want %b00", k, level1, busy1,
                 glitch1, (k < L));
      end
    end
  endtask

  initial begin
    rst = 1'b0; signal = 1'b0; sig1 = 1'b0;
    test_reset();
    test_short_pulse();
    test_clean_step();
    test_falling_chatter();
    test_toggle();
    test_reset_mid_count();
    test_stable_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
